// File: rtl/io_port_unit_if.sv
// Memory-stage / external-side bus of the I/O port unit.
// slave: the port unit itself; master: memory stage plus external devices.
interface io_port_unit_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic        rd_sel;
  logic [15:0] rd_data;
  logic        hold;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport slave (
    input  wr_en, wr_data, rd_en, rd_sel, out_ready, in_data, in_valid,
    output rd_data, hold, out_data, out_valid, in_ready
  );

  modport master (
    output wr_en, wr_data, rd_en, rd_sel, out_ready, in_data, in_valid,
    input  rd_data, hold, out_data, out_valid, in_ready
  );
endinterface

// File: rtl/io_port_unit.sv
// Memory-mapped I/O port: stores queue into a DEPTH-entry output FIFO,
// loads read a one-entry input buffer or a status word. hold stalls the
// pipeline when a store meets a full FIFO or a data load finds no input.
module io_port_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clock,
  input  logic           rst,
  io_port_unit_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   in_buf_q, in_buf_d;
  logic          in_full_q, in_full_d;
  logic [7:0]    tx_cnt_q, tx_cnt_d;
  logic [7:0]    rx_cnt_q, rx_cnt_d;

  logic fifo_full;
  logic hold;
  logic push, pop, consume, capture;
  logic [15:0] rd_data;

  assign fifo_full = (count_q == DEPTH_C);

  // Stall decision and the request qualifiers; a stalled cycle performs
  // neither the push nor the consume so the retry is atomic.
  always_comb begin
    hold    = (bus.wr_en && fifo_full) ||
              (bus.rd_en && !bus.rd_sel && !in_full_q);
    push    = bus.wr_en && !fifo_full && !hold;
    consume = bus.rd_en && !bus.rd_sel && in_full_q && !hold;
    pop     = (count_q != '0) && bus.out_ready;
    capture = bus.in_valid && !in_full_q;
  end

  // Load result mux: input word, status word, or zero.
  always_comb begin
    rd_data = '0;
    if (bus.rd_en) begin
      if (bus.rd_sel)
        rd_data = {tx_cnt_q, 6'(count_q), in_full_q, fifo_full};
      else if (in_full_q)
        rd_data = in_buf_q;
    end
  end

  // Next-state for pointers, occupancy, input buffer and counters.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    in_buf_d  = in_buf_q;
    in_full_d = in_full_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    if (push)
      wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d   = rptr_q + 1'b1;
      tx_cnt_d = tx_cnt_q + 8'd1;
    end
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
    if (capture) begin
      in_buf_d  = bus.in_data;
      in_full_d = 1'b1;
      rx_cnt_d  = rx_cnt_q + 8'd1;
    end else if (consume) begin
      in_full_d = 1'b0;
    end
  end

  // Control state, cleared asynchronously; FIFO storage is not reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      in_buf_q  <= '0;
      in_full_q <= 1'b0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      in_buf_q  <= in_buf_d;
      in_full_q <= in_full_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clock) begin
    if (push)
      mem_q[wptr_q] <= bus.wr_data;
  end

  assign bus.rd_data   = rd_data;
  assign bus.hold      = hold;
  assign bus.out_data  = mem_q[rptr_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.in_ready  = !in_full_q;

endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;
  logic clock = 1'b0;
  logic rst   = 1'b1;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  io_port_unit_if bus();

  io_port_unit #(.DEPTH(4)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.wr_data = '0; bus.rd_en = 0; bus.rd_sel = 0;
    bus.out_ready = 0; bus.in_valid = 0; bus.in_data = '0;
  endtask

  task automatic status(input string tag, input logic [15:0] exp);
    bus.rd_en = 1; bus.rd_sel = 1;
    #1;
    check(tag, bus.rd_data, exp);
    check({tag, "_hold"}, {15'd0, bus.hold}, 16'd0);
    bus.rd_en = 0; bus.rd_sel = 0;
  endtask

  task automatic push_word(input logic [15:0] d);
    bus.wr_en = 1; bus.wr_data = d;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic drain_expect(input string tag, input logic [15:0] d);
    bus.out_ready = 1;
    #1;
    check({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
    check(tag, bus.out_data, d);
    tick();
    bus.out_ready = 0;
  endtask

  logic [15:0] wdat;

  initial begin
    idle();
    tick(); tick();
    // reset state while held
    #1;
    check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_in_ready",  {15'd0, bus.in_ready},  16'd1);
    check("rst_hold",      {15'd0, bus.hold},      16'd0);
    check("rst_rd_data",   bus.rd_data,            16'd0);
    tick();
    rst = 0;
    tick();

    // push and drain
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    #1;
    check("pd_head", bus.out_data, 16'h1111);
    status("pd_status_cnt3", 16'h000C);
    drain_expect("pd_d0", 16'h1111);
    drain_expect("pd_d1", 16'h2222);
    drain_expect("pd_d2", 16'h3333);
    #1;
    check("pd_empty", {15'd0, bus.out_valid}, 16'd0);
    status("pd_status_tx3", 16'h0300);

    // full FIFO
    push_word(16'hA001);
    push_word(16'hA002);
    push_word(16'hA003);
    push_word(16'hA004);
    bus.wr_en = 1; bus.wr_data = 16'hBEEF; bus.out_ready = 1;
    bus.rd_en = 1; bus.rd_sel = 1;
    #1;
    check("full_hold", {15'd0, bus.hold}, 16'd1);
    check("full_status", bus.rd_data, 16'h0311);
    check("full_head", bus.out_data, 16'hA001);
    tick();
    bus.out_ready = 0;
    #1;
    check("full_status_after_pop", bus.rd_data, 16'h040C);
    check("full_retry_hold", {15'd0, bus.hold}, 16'd0);
    tick();
    idle();
    status("full_status_refill", 16'h0411);
    drain_expect("full_d0", 16'hA002);
    drain_expect("full_d1", 16'hA003);
    drain_expect("full_d2", 16'hA004);
    drain_expect("full_d3", 16'hBEEF);
    #1;
    check("full_empty", {15'd0, bus.out_valid}, 16'd0);

    // empty input buffer
    bus.rd_en = 1; bus.rd_sel = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ein_hold", {15'd0, bus.hold}, 16'd1);
      check("ein_rd_data", bus.rd_data, 16'd0);
      tick();
    end
    bus.in_valid = 1; bus.in_data = 16'hA5A5;
    #1;
    check("ein_in_ready", {15'd0, bus.in_ready}, 16'd1);
    tick();
    bus.in_valid = 0; bus.in_data = '0;
    #1;
    check("ein_hold_release", {15'd0, bus.hold}, 16'd0);
    check("ein_rd_data_word", bus.rd_data, 16'hA5A5);
    check("ein_in_ready_full", {15'd0, bus.in_ready}, 16'd0);
    tick();
    bus.rd_en = 0;
    #1;
    check("ein_in_ready_back", {15'd0, bus.in_ready}, 16'd1);

    // simultaneous stall: FIFO full and input buffer full
    push_word(16'hC001);
    push_word(16'hC002);
    push_word(16'hC003);
    push_word(16'hC004);
    bus.in_valid = 1; bus.in_data = 16'h5A5A;
    tick();
    bus.in_valid = 0; bus.in_data = '0;
    bus.wr_en = 1; bus.wr_data = 16'hD00D; bus.rd_en = 1; bus.rd_sel = 0;
    #1;
    check("sim_hold", {15'd0, bus.hold}, 16'd1);
    check("sim_rd_data", bus.rd_data, 16'h5A5A);
    tick();
    check("sim_in_full_kept", {15'd0, bus.in_ready}, 16'd0);
    check("sim_hold_still", {15'd0, bus.hold}, 16'd1);
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    #1;
    check("sim_hold_clear", {15'd0, bus.hold}, 16'd0);
    check("sim_rd_data2", bus.rd_data, 16'h5A5A);
    tick();
    idle();
    #1;
    check("sim_consumed", {15'd0, bus.in_ready}, 16'd1);
    status("sim_status", 16'h0911);
    drain_expect("sim_d0", 16'hC002);
    drain_expect("sim_d1", 16'hC003);
    drain_expect("sim_d2", 16'hC004);
    drain_expect("sim_d3", 16'hD00D);

    // reset mid-operation, asserted mid-cycle
    push_word(16'hE001);
    bus.in_valid = 1; bus.in_data = 16'h1234;
    tick();
    idle();
    #3;
    rst = 1;
    #1;
    check("mrst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("mrst_in_ready",  {15'd0, bus.in_ready},  16'd1);
    check("mrst_hold",      {15'd0, bus.hold},      16'd0);
    check("mrst_rd_data",   bus.rd_data,            16'd0);
    status("mrst_status", 16'h0000);
    tick();
    rst = 0;
    tick();

    // pointer wrap: 300 push/pop pairs
    bus.out_ready = 1;
    for (int i = 0; i < 300; i++) begin
      wdat = 16'(i) ^ 16'h5A00;
      bus.wr_en = 1; bus.wr_data = wdat;
      #1;
      if (i > 0) check("wrap_data", bus.out_data, (16'(i - 1) ^ 16'h5A00));
      tick();
    end
    bus.wr_en = 0;
    #1;
    check("wrap_last", bus.out_data, (16'd299 ^ 16'h5A00));
    tick();
    bus.out_ready = 0;
    #1;
    check("wrap_empty", {15'd0, bus.out_valid}, 16'd0);
    status("wrap_status_tx44", 16'h2C00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
